// File: rtl/a_row_loader_pkg.sv
// Shared types and sizing helpers for the A-operand row loader.
// Optional statistics counters are enabled by defining A_ROW_LOADER_STATS_EN.
package a_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_WRITE  = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } a_ld_state_t;

    localparam int DEF_BITS_AB = 8;
    localparam int DEF_DIM     = 8;

    // Cycles needed to push the skewed buffer contents fully into the array.
    function automatic int drain_cycles(input int dim);
        return (3 * dim) - 2;
    endfunction

    // Counter width for values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ELEM_W  = cnt_width(DEF_DIM);
    localparam int ROW_W   = cnt_width(DEF_DIM);
    localparam int DRAIN_W = cnt_width(drain_cycles(DEF_DIM) + 1);

endpackage

// File: rtl/a_row_loader_if.sv
// Stream-in / buffer-out bundle of the A row loader; the stats outputs exist
// only when A_ROW_LOADER_STATS_EN is defined.
interface a_row_loader_if
    import a_loader_pkg::*;
#(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int DIM     = DEF_DIM
);
    localparam int RW = cnt_width(DIM);

    logic                          start;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [BITS_AB-1:0]     in_data;
    logic [DIM-1:0][BITS_AB-1:0]   Ain;
    logic [RW-1:0]                 Arow;
    logic                          WrEn;
    logic                          en;
    logic                          busy;
    logic                          done;
`ifdef A_ROW_LOADER_STATS_EN
    logic [15:0]                   stall_cycles;
    logic [15:0]                   loads_done;

    modport master (output start, in_valid, in_data,
                    input  in_ready, Ain, Arow, WrEn, en, busy, done,
                           stall_cycles, loads_done);
    modport slave  (input  start, in_valid, in_data,
                    output in_ready, Ain, Arow, WrEn, en, busy, done,
                           stall_cycles, loads_done);
`else
    modport master (output start, in_valid, in_data,
                    input  in_ready, Ain, Arow, WrEn, en, busy, done);
    modport slave  (input  start, in_valid, in_data,
                    output in_ready, Ain, Arow, WrEn, en, busy, done);
`endif
endinterface

// File: rtl/a_row_loader_packer.sv
// Packs accepted stream elements into the Ain lane registers, one lane per
// handshake, and flags the handshake that completes a row.
module a_row_packer
    import a_loader_pkg::*;
#(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int DIM     = DEF_DIM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        fire,
    input  logic signed [BITS_AB-1:0]   in_data,
    output logic [DIM-1:0][BITS_AB-1:0] Ain,
    output logic                        row_full
);
    localparam int CW = cnt_width(DIM);

    logic [CW-1:0]               elem_r;
    logic [DIM-1:0][BITS_AB-1:0] lanes_r;
    logic                        last_s;

    assign last_s   = (elem_r == CW'(DIM - 1));
    assign row_full = fire && last_s;
    assign Ain      = lanes_r;

    // Lane capture and element counter; the counter restarts on the row's last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_r  <= '0;
            lanes_r <= '0;
        end else if (clr) begin
            elem_r  <= '0;
        end else if (fire) begin
            lanes_r[elem_r] <= in_data;
            elem_r          <= last_s ? CW'(0) : (elem_r + CW'(1));
        end else begin
            elem_r  <= elem_r;
        end
    end

endmodule

// File: rtl/a_row_loader.sv
// A-operand row loader: fills DIM rows from a stream, writes them to the skewed
// buffer, drains it, then pulses done. Define A_ROW_LOADER_STATS_EN for counters.
module a_row_loader
    import a_loader_pkg::*;
#(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int DIM     = DEF_DIM
) (
    input  logic           clk,
    input  logic           rst,
    a_row_loader_if.slave  bus
);
    localparam int RW    = cnt_width(DIM);
    localparam int DRAIN = drain_cycles(DIM);
    localparam int DW    = cnt_width(DRAIN + 1);

    a_ld_state_t               state_r;
    logic [RW-1:0]             row_r;
    logic [DW-1:0]             drain_r;
    logic                      in_ready_r;
    logic                      wr_en_r;
    logic                      en_r;
    logic                      busy_r;
    logic                      done_r;
    logic [RW-1:0]             arow_r;
    logic                      fire_s;
    logic                      clr_s;
    logic                      row_full_s;
    logic [DIM-1:0][BITS_AB-1:0] ain_s;

    // in_ready is high exactly in FILL, so a handshake implies FILL.
    assign fire_s = bus.in_valid && in_ready_r;
    assign clr_s  = (state_r == S_IDLE);

    a_row_packer #(.BITS_AB(BITS_AB), .DIM(DIM)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .fire     (fire_s),
        .in_data  (bus.in_data),
        .Ain      (ain_s),
        .row_full (row_full_s)
    );

    assign bus.Ain      = ain_s;
    assign bus.Arow     = arow_r;
    assign bus.in_ready = in_ready_r;
    assign bus.WrEn     = wr_en_r;
    assign bus.en       = en_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

    // Load sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            row_r      <= '0;
            drain_r    <= '0;
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            en_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            arow_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    row_r   <= '0;
                    drain_r <= '0;
                    if (bus.start) begin
                        state_r    <= S_FILL;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (row_full_s) begin
                        state_r    <= S_WRITE;
                        in_ready_r <= 1'b0;
                        wr_en_r    <= 1'b1;
                        arow_r     <= row_r;
                    end else begin
                        state_r    <= S_FILL;
                    end
                end
                S_WRITE: begin
                    wr_en_r <= 1'b0;
                    if (row_r == RW'(DIM - 1)) begin
                        state_r <= S_STREAM;
                        en_r    <= 1'b1;
                        drain_r <= '0;
                    end else begin
                        state_r    <= S_FILL;
                        row_r      <= row_r + RW'(1);
                        in_ready_r <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (drain_r == DW'(DRAIN - 1)) begin
                        state_r <= S_DONE;
                        en_r    <= 1'b0;
                        done_r  <= 1'b1;
                        drain_r <= '0;
                    end else begin
                        drain_r <= drain_r + DW'(1);
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= S_IDLE;
                    row_r      <= '0;
                    drain_r    <= '0;
                    in_ready_r <= 1'b0;
                    wr_en_r    <= 1'b0;
                    en_r       <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef A_ROW_LOADER_STATS_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] loads_cnt_r;

    // Stall counter saturates; load counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
            loads_cnt_r <= 16'h0000;
        end else begin
            if ((state_r == S_FILL) && !bus.in_valid && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (done_r) begin
                loads_cnt_r <= loads_cnt_r + 16'h0001;
            end else begin
                loads_cnt_r <= loads_cnt_r;
            end
        end
    end

    assign bus.stall_cycles = stall_cnt_r;
    assign bus.loads_done   = loads_cnt_r;
`endif

endmodule

// File: tb/tb_a_row_loader.sv
// Bench for a_row_loader: a per-cycle expected timeline is built from the load
// rules (fill/write/drain/done) and compared against the DUT every cycle.
module tb_a_row_loader;
    import a_loader_pkg::*;

    localparam int DIM   = 8;
    localparam int B     = 8;
    localparam int N     = 512;
    localparam int DRAIN = 3 * DIM - 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a_row_loader_if #(.BITS_AB(B), .DIM(DIM)) bif();
    a_row_loader #(.BITS_AB(B), .DIM(DIM)) dut (.clk(clk), .rst(rst), .bus(bif));

    int total = 0;
    int bad   = 0;

    bit          st_a [N];
    bit          v_a  [N];
    logic [7:0]  d_a  [N];
    logic [71:0] exp_a[N];
    logic [7:0]  lanes[DIM];
    int          mdl_arow;
    int          last_cyc;
    int          done_cyc;
    int          stalls;
    int          act_done;

    typedef struct {
        int vmode;      // 0 always valid, 1 one idle cycle before each element, 2 random
        int dmode;      // 0 values 1..64, 1 all -128, 2 random
        bit noise;      // extra start pulses during FILL and STREAM
        int exp_done;   // cycle of done after start, -1 = take from model
        int exp_stalls; // -1 = take from model
    } vec_t;

    vec_t tbl[4];

    function automatic logic [71:0] pack_exp(bit rdy, bit wr, bit en, bit busy, bit done);
        logic [63:0] a;
        for (int k = 0; k < DIM; k++) a[k*8 +: 8] = lanes[k];
        return {rdy, wr, en, busy, done, 3'(mdl_arow), a};
    endfunction

    function automatic logic [71:0] pack_act();
        return {bif.in_ready, bif.WrEn, bif.en, bif.busy, bif.done, bif.Arow, bif.Ain};
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Build the stimulus and expected output of one complete load.
    task automatic gen(input int vmode, input int dmode, input bit noise);
        int t;
        int idx;
        int k;
        bit val;
        bit ph;
        logic [7:0] elems[64];
        for (int i = 0; i < 64; i++)
            elems[i] = (dmode == 0) ? 8'(i + 1) : (dmode == 1) ? 8'h80 : 8'($urandom);
        for (int i = 0; i < N; i++) begin
            st_a[i] = 1'b0;
            v_a[i]  = 1'b0;
            d_a[i]  = 8'($urandom);
        end
        stalls   = 0;
        exp_a[0] = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st_a[0]  = 1'b1;
        t   = 1;
        idx = 0;
        for (int r = 0; r < DIM; r++) begin
            k  = 0;
            ph = 1'b0;
            while (k < DIM) begin
                exp_a[t] = pack_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                case (vmode)
                    0:       val = 1'b1;
                    1:       begin val = ph; ph = !ph; end
                    default: val = (t > 300) || ($urandom_range(0, 3) != 0);
                endcase
                v_a[t] = val;
                if (val) begin
                    d_a[t]   = elems[idx];
                    lanes[k] = elems[idx];
                    idx++;
                    k++;
                end else begin
                    stalls++;
                end
                if (noise && r == 1 && k == 2) st_a[t] = 1'b1;
                t++;
            end
            mdl_arow = r;
            exp_a[t] = pack_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            if (vmode == 2) v_a[t] = 1'($urandom);
            t++;
        end
        for (int i = 0; i < DRAIN; i++) begin
            exp_a[t] = pack_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            if (noise && i == 5) st_a[t] = 1'b1;
            t++;
        end
        exp_a[t] = pack_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        done_cyc = t;
        t++;
        for (int i = 0; i < 3; i++) begin
            exp_a[t] = pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            t++;
        end
        last_cyc = t;
    endtask

    // Apply the first n cycles of the generated load, checking each cycle.
    task automatic exec(input int n);
        act_done = -1;
        for (int t = 0; t < n; t++) begin
            chk($sformatf("cyc%0d", t), pack_act(), exp_a[t]);
            if (bif.done && act_done < 0) act_done = t;
            bif.start    = st_a[t];
            bif.in_valid = v_a[t];
            bif.in_data  = d_a[t];
            @(posedge clk);
            #1;
        end
        bif.start    = 1'b0;
        bif.in_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < DIM; k++) lanes[k] = 8'h00;
        mdl_arow = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
`ifdef A_ROW_LOADER_STATS_EN
        logic [15:0] s0;
        logic [15:0] l0;
`endif
        tbl[0] = '{vmode: 0, dmode: 0, noise: 1'b0, exp_done: 95,  exp_stalls: 0};
        tbl[1] = '{vmode: 1, dmode: 0, noise: 1'b0, exp_done: 159, exp_stalls: 64};
        tbl[2] = '{vmode: 0, dmode: 1, noise: 1'b1, exp_done: 95,  exp_stalls: 0};
        tbl[3] = '{vmode: 2, dmode: 2, noise: 1'b1, exp_done: -1,  exp_stalls: -1};

        bif.start    = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", pack_act(), 72'h0);
        rst = 1'b0;
`ifdef A_ROW_LOADER_STATS_EN
        chk("reset_stats", 72'({bif.stall_cycles, bif.loads_done}), 72'h0);
`endif

        for (int i = 0; i < 4; i++) begin
`ifdef A_ROW_LOADER_STATS_EN
            s0 = bif.stall_cycles;
            l0 = bif.loads_done;
`endif
            gen(tbl[i].vmode, tbl[i].dmode, tbl[i].noise);
            exec(last_cyc);
            chk($sformatf("done_cyc_v%0d", i), 72'(act_done),
                72'((tbl[i].exp_done >= 0) ? tbl[i].exp_done : done_cyc));
`ifdef A_ROW_LOADER_STATS_EN
            chk($sformatf("stalls_v%0d", i), 72'(16'(bif.stall_cycles - s0)),
                72'((tbl[i].exp_stalls >= 0) ? tbl[i].exp_stalls : stalls));
            chk($sformatf("loads_v%0d", i), 72'(16'(bif.loads_done - l0)), 72'd1);
`endif
        end

        // Reset after three elements of row 2, then a fresh load from row 0.
        gen(0, 0, 1'b0);
        exec(22);
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h55;
        pulse_reset();
        chk("rst_mid_row", pack_act(), 72'h0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rst_mid_quiet%0d", i),
                72'({bif.WrEn, bif.en, bif.busy, bif.done, bif.in_ready}), 72'h0);
            @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b0;
`ifdef A_ROW_LOADER_STATS_EN
        chk("rst_mid_stats", 72'({bif.stall_cycles, bif.loads_done}), 72'h0);
`endif
        gen(0, 0, 1'b0);
        exec(last_cyc);
        chk("replay_done_cyc", 72'(act_done), 72'd95);

        // Reset on the 10th drain cycle: en drops and done never appears.
        gen(0, 0, 1'b0);
        exec(82);
        chk("en_before_rst", 72'(bif.en), 72'd1);
        pulse_reset();
        chk("rst_stream", pack_act(), 72'h0);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("rst_stream_quiet%0d", i),
                72'({bif.WrEn, bif.en, bif.busy, bif.done}), 72'h0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a_row_loader.md
# a_row_loader

Front-end controller for the A-operand path of the systolic matrix multiplier. Accepts A elements one per handshake from a valid/ready stream, packs DIM of them into a row, and writes each completed row into the skewed A transpose buffer via its row-write port. After all DIM rows are written, it drives the buffer's shift enable for exactly enough cycles to drain the skewed data into the array, then pulses `done`.

## Interface
- `BITS_AB`, 8: signed element width.
- `DIM`, 8: matrix dimension; rows per matrix and elements per row.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin loading one matrix; sampled only in IDLE.
- `in_valid`  in  1  stream element valid.
- `in_ready`  out  1  stream element accepted when `in_valid && in_ready`.
- `in_data`  in  BITS_AB  signed element; row-major order.
- `Ain`  out  BITS_AB x DIM  packed row to the buffer; element k is the (k+1)-th accepted element of the row.
- `Arow`  out  $clog2(DIM)  row index for the current write.
- `WrEn`  out  1  row-write strobe.
- `en`  out  1  buffer shift enable.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FILL, WRITE, STREAM, DONE.
- IDLE: `start` goes to FILL. Row counter and element counter are cleared.
- FILL: `in_ready` is 1. Each handshake stores `in_data` at `Ain[elem]` and increments `elem`. On the handshake with `elem == DIM-1`, the next state is WRITE.
- WRITE: held for one cycle. `WrEn=1` and `Arow=row`. If `row == DIM-1`, the next state is STREAM; otherwise `row` increments, `elem` clears, and the next state is FILL.
- STREAM: `en=1` for exactly DRAIN = 3*DIM-2 cycles, counted by the drain counter. The next state is DONE.
- DONE: `done=1` for one cycle. The next state is IDLE.
- `en` and `WrEn` are never high in the same cycle.
- `Ain` holds its value outside FILL. Stale lanes are overwritten before each WRITE.
- `start` outside IDLE is ignored.
- Stalls (`in_valid=0`) in FILL hold all state indefinitely.
- Counter widths: `elem` and `row` are $clog2(DIM) bits; the drain counter is $clog2(3*DIM-1) bits. No wrap-around occurs: each counter is cleared before it exceeds its bound.
- Reset in any state:
  - Next cycle is IDLE with all counters 0.
  - A partial row is discarded.
  - No `WrEn`, `en` or `done` is issued for the aborted load.

## Timing
- Reset values:
  - `in_ready`, `WrEn`, `en`, `busy`, `done` = 0.
  - `Arow` = 0.
  - All `Ain` lanes = 0.
- All outputs are registered or decoded from registered state only. No combinational path exists from `in_valid` or `start` to any output.
- `start` at cycle t gives `busy=1` and `in_ready=1` at t+1.
- The final handshake of a row at cycle t gives `WrEn=1` at t+1, with `Ain` and `Arow` valid in that same cycle.
- With `in_valid` held high:
  - Each row takes DIM+1 cycles.
  - The whole load takes DIM*(DIM+1) cycles, then DRAIN cycles of `en`, then 1 cycle of `done`.
  - For DIM=8 this is 72 + 22 + 1 cycles.

## Configuration
- `A_ROW_LOADER_STATS_EN`, when defined, adds:
  - output `stall_cycles` (16 bits): counts FILL cycles with `in_valid=0` and saturates at 0xFFFF.
  - output `loads_done` (16 bits): increments on each `done` and wraps.
- Both counters clear on `rst` only.
- When undefined, neither port nor any of its logic exists.

## Structure
- Shared package `a_loader_pkg` holds:
  - the state enum `a_ld_state_t`;
  - a function computing DRAIN from DIM;
  - the counter-width localparams.
- One sub-module is natural: `a_row_packer`. It contains the `Ain` lane registers plus the element counter, and signals `row_full`.

## Test plan
- Basic load: DIM=8, reset, `start`, then 64 elements with values 1..64 and `in_valid` held high.
  - 8 `WrEn` pulses with `Arow` 0..7.
  - Row r has `Ain[k]=8r+k+1`.
  - `en` is high for 22 cycles, then `done` at cycle 95 after `start`.
- Backpressure: same data with `in_valid` low every other cycle.
  - Identical `Ain`/`Arow` sequence.
  - `WrEn` spacing grows to 17 cycles.
  - With stats enabled, `stall_cycles` = 64.
- Negative data: all elements -128 (0x80). Every `Ain` lane reads 0x80 at each `WrEn`.
- `start` ignored: `start` pulsed again during FILL and during STREAM. Only one `done`; the `Arow` sequence is unchanged.
- Reset mid-row: `rst` after 3 elements of row 2.
  - Next cycle: IDLE, all outputs at reset values, no `WrEn`.
  - A fresh `start` replays from `Arow=0`.
- Reset during STREAM: `rst` at the 10th `en` cycle. `en` drops the next cycle and `done` never fires.
